// File: rtl/mem_arbiter_if.sv
// Bundled requester, halt and memory-port signals of the shared memory arbiter.
// Handshake: a requester raises x_req with we/addr/wdata and holds them stable until the
// cycle x_ack is high; that cycle is the transfer. A read returns on x_rvalid two cycles later.
interface mem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic          if_rvalid;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic          dm_rvalid;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic          dbg_rvalid;

    logic [DW-1:0] rdata;
    logic          halt;
    logic          halt_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
               dbg_req, dbg_we, dbg_addr, dbg_wdata, halt, mem_rdata,
        output if_ack, if_rvalid, dm_ack, dm_rvalid, dbg_ack, dbg_rvalid,
               rdata, halt_ack, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
               dbg_req, dbg_we, dbg_addr, dbg_wdata, halt, mem_rdata,
        input  if_ack, if_rvalid, dm_ack, dm_rvalid, dbg_ack, dbg_rvalid,
               rdata, halt_ack, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch, data and debug requesters with fetch
// anti-starvation boost and a halt/drain sequence.
module mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    mem_arbiter_if.slave                      bus,
    output logic [1:0]                        fsm_state,
    output logic [$clog2(STARVE_LIM+1)-1:0]   starve_cnt
);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [1:0] OWN_IF  = 2'd0;
    localparam logic [1:0] OWN_DM  = 2'd1;
    localparam logic [1:0] OWN_DBG = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [SW-1:0] starve;
    logic          if_elig, dm_elig, boost;
    logic          gnt_if, gnt_dm, gnt_dbg, gnt_any, gnt_we;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_wdata;
    logic [1:0]    gnt_own;
    logic          p1_v, p2_v;
    logic [1:0]    p1_own, p2_own;
    logic          mem_en_q, mem_we_q, halt_ack_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;

    // Fetch stops being eligible in the very cycle halt is raised.
    always_comb begin
        if_elig = rst_n && (state == ST_RUN) && !bus.halt;
        dm_elig = rst_n && (state != ST_HALTED);
        boost   = (starve == STARVE_MAX);
        gnt_dbg = rst_n && bus.dbg_req;
        gnt_if  = if_elig && bus.if_req && !bus.dbg_req && (boost || !bus.dm_req);
        gnt_dm  = dm_elig && bus.dm_req && !bus.dbg_req && !gnt_if;
        gnt_any = gnt_if || gnt_dm || gnt_dbg;
    end

    always_comb begin
        gnt_we    = 1'b0;
        gnt_addr  = bus.if_addr;
        gnt_wdata = '0;
        gnt_own   = OWN_IF;
        if (gnt_dbg) begin
            gnt_we    = bus.dbg_we;
            gnt_addr  = bus.dbg_addr;
            gnt_wdata = bus.dbg_wdata;
            gnt_own   = OWN_DBG;
        end else if (gnt_dm) begin
            gnt_we    = bus.dm_we;
            gnt_addr  = bus.dm_addr;
            gnt_wdata = bus.dm_wdata;
            gnt_own   = OWN_DM;
        end
    end

    // p1/p2 hold reads granted one and two cycles ago; either means memory is busy.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (bus.halt) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!bus.halt)                         state_nxt = ST_RUN;
                else if (!bus.dm_req && !p1_v && !p2_v) state_nxt = ST_HALTED;
            end
            ST_HALTED: if (!bus.halt) state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            starve      <= '0;
            halt_ack_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            p1_v        <= 1'b0;
            p1_own      <= OWN_IF;
            p2_v        <= 1'b0;
            p2_own      <= OWN_IF;
        end else begin
            state      <= state_nxt;
            halt_ack_q <= (state_nxt == ST_HALTED);
            if (state == ST_RUN) begin
                if (!bus.if_req || gnt_if)  starve <= '0;
                else if (starve != STARVE_MAX) starve <= starve + SW'(1);
            end
            mem_en_q <= gnt_any;
            mem_we_q <= gnt_any && gnt_we;
            if (gnt_any) begin
                mem_addr_q  <= gnt_addr;
                mem_wdata_q <= gnt_wdata;
            end
            p1_v   <= gnt_any && !gnt_we;
            p1_own <= gnt_own;
            p2_v   <= p1_v;
            p2_own <= p1_own;
        end
    end

    assign bus.if_ack     = gnt_if;
    assign bus.dm_ack     = gnt_dm;
    assign bus.dbg_ack    = gnt_dbg;
    assign bus.if_rvalid  = p2_v && (p2_own == OWN_IF);
    assign bus.dm_rvalid  = p2_v && (p2_own == OWN_DM);
    assign bus.dbg_rvalid = p2_v && (p2_own == OWN_DBG);
    assign bus.rdata      = bus.mem_rdata;
    assign bus.halt_ack   = halt_ack_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign fsm_state      = state;
    assign starve_cnt     = starve;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then randomized traffic, checked against
// a cycle-level model of the arbitration rules and a simple synchronous RAM.
module tb_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int STARVE_LIM = 4;

    localparam int G_NONE = 0, G_IF = 1, G_DM = 2, G_DBG = 3;
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] fsm_state;
    logic [2:0] starve_cnt;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(STARVE_LIM)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .fsm_state  (fsm_state),
        .starve_cnt (starve_cnt)
    );

    // clock / reset block
    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    // reference model state
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];
    int            ret_own [int];
    int            m_state, m_starve, cyc, last_g;
    int            n_tests, n_fail;
    logic          exp_men, exp_mwe;
    logic [AW-1:0] exp_maddr;
    logic [DW-1:0] exp_mwdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int model_grant();
        if (bus.dbg_req) return G_DBG;
        if (m_state == M_RUN && !bus.halt && bus.if_req && m_starve == STARVE_LIM) return G_IF;
        if (bus.dm_req && m_state != M_HALTED) return G_DM;
        if (bus.if_req && m_state == M_RUN && !bus.halt) return G_IF;
        return G_NONE;
    endfunction

    task automatic idle();
        bus.if_req = 0; bus.if_addr = '0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    endtask

    // driver: called at posedge+1 with inputs set; checks acks at negedge, outputs after edge
    task automatic step();
        int         g, own;
        logic       busy;
        logic [2:0] exp_ack;
        #4;
        g = model_grant();
        exp_ack = {g == G_DBG, g == G_DM, g == G_IF};
        check("ack", {bus.dbg_ack, bus.dm_ack, bus.if_ack}, exp_ack);
        busy = ret_own.exists(cyc) || ret_own.exists(cyc + 1);
        exp_men = (g != G_NONE);
        exp_mwe = 1'b0;
        case (g)
            G_IF:  exp_maddr = bus.if_addr;
            G_DM:  begin exp_maddr = bus.dm_addr;  exp_mwe = bus.dm_we;  exp_mwdata = bus.dm_wdata;  end
            G_DBG: begin exp_maddr = bus.dbg_addr; exp_mwe = bus.dbg_we; exp_mwdata = bus.dbg_wdata; end
            default: ;
        endcase
        if (exp_men && !exp_mwe) begin
            ret_own[cyc + 2] = g;
            exp_q.push_back(ref_mem[exp_maddr]);
        end else if (exp_mwe) begin
            ref_mem[exp_maddr] = exp_mwdata;
        end
        if (m_state == M_RUN) begin
            if (!bus.if_req || g == G_IF) m_starve = 0;
            else if (m_starve < STARVE_LIM) m_starve++;
        end
        case (m_state)
            M_RUN:   if (bus.halt) m_state = M_DRAIN;
            M_DRAIN: if (!bus.halt) m_state = M_RUN;
                     else if (!bus.dm_req && !busy) m_state = M_HALTED;
            default: if (!bus.halt) m_state = M_RUN;
        endcase
        last_g = g;
        @(posedge clk);
        cyc++;
        #1;
        check("mem_en", bus.mem_en, exp_men);
        check("mem_we", bus.mem_we, exp_mwe);
        if (exp_men) check("mem_addr", bus.mem_addr, exp_maddr);
        if (exp_mwe) check("mem_wdata", bus.mem_wdata, exp_mwdata);
        own = ret_own.exists(cyc) ? ret_own[cyc] : G_NONE;
        check("rvalid", {bus.dbg_rvalid, bus.dm_rvalid, bus.if_rvalid},
              {own == G_DBG, own == G_DM, own == G_IF});
        if (own != G_NONE) check("rdata", bus.rdata, exp_q.pop_front());
        check("halt_ack", bus.halt_ack, m_state == M_HALTED);
        check("starve", starve_cnt, m_starve);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_mem_en"}, bus.mem_en, 1'b0);
        check({tag, "_mem_we"}, bus.mem_we, 1'b0);
        check({tag, "_mem_addr"}, bus.mem_addr, '0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, '0);
        check({tag, "_halt_ack"}, bus.halt_ack, 1'b0);
        check({tag, "_rvalid"}, {bus.dbg_rvalid, bus.dm_rvalid, bus.if_rvalid}, 3'b000);
        check({tag, "_ack"}, {bus.dbg_ack, bus.dm_ack, bus.if_ack}, 3'b000);
        check({tag, "_starve"}, starve_cnt, 0);
    endtask

    // async reset in the middle of a cycle, released just after the next edge
    task automatic rst_pulse();
        #1 rst_n = 1'b0;
        #1 check_reset_state("rst_mid");
        m_state = M_RUN;
        m_starve = 0;
        ret_own.delete();
        exp_q.delete();
        @(posedge clk);
        cyc++;
        #1 check_reset_state("rst_edge");
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; last_g = G_NONE;
        m_state = M_RUN; m_starve = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = 32'hA500_0000 ^ (i * 32'h0001_0203);
            ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0203);
        end
        idle();
        bus.halt = 1'b0;
        #2 rst_n = 1'b0;
        bus.if_req = 1'b1; bus.dbg_req = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_reset_state("por");
        idle();
        rst_n = 1'b1;

        // consecutive fetches of words 0..3
        for (int i = 0; i < 4; i++) begin
            bus.if_req = 1'b1; bus.if_addr = AW'(i);
            step();
        end
        idle();
        repeat (2) step();

        // data reads hold off fetch until the starvation boost
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd40;
        bus.if_req = 1'b1; bus.if_addr = 10'd7;
        repeat (6) step();
        idle();
        repeat (2) step();

        // debug write and data read to the same address in one cycle
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 10'd30; bus.dbg_wdata = 32'h15;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd30;
        step();
        bus.dbg_req = 1'b0;
        step();
        idle();
        repeat (2) step();

        // halt with a data read in flight, debug write while halted, resume
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd12;
        bus.if_req = 1'b1; bus.if_addr = 10'd9;
        step();
        bus.dm_req = 1'b0; bus.halt = 1'b1;
        repeat (4) step();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 10'd50; bus.dbg_wdata = $urandom;
        step();
        bus.dbg_req = 1'b0;
        step();
        bus.halt = 1'b0;
        repeat (3) step();
        idle();
        repeat (2) step();

        // reset one cycle after a fetch read grant
        bus.if_req = 1'b1; bus.if_addr = 10'd5;
        step();
        rst_pulse();
        bus.if_addr = 10'd6;
        step();
        idle();
        repeat (2) step();

        // randomized traffic honouring hold-until-ack
        for (int n = 0; n < 300; n++) begin
            if (!bus.if_req || last_g == G_IF) begin
                bus.if_req  = ($urandom_range(0, 3) != 0);
                bus.if_addr = AW'($urandom_range(0, 63));
            end
            if (!bus.dm_req || last_g == G_DM) begin
                bus.dm_req   = ($urandom_range(0, 2) != 0);
                bus.dm_we    = 1'($urandom_range(0, 1));
                bus.dm_addr  = AW'($urandom_range(0, 63));
                bus.dm_wdata = $urandom;
            end
            if (!bus.dbg_req || last_g == G_DBG) begin
                bus.dbg_req   = ($urandom_range(0, 7) == 0);
                bus.dbg_we    = 1'($urandom_range(0, 1));
                bus.dbg_addr  = AW'($urandom_range(0, 63));
                bus.dbg_wdata = $urandom;
            end
            if ($urandom_range(0, 19) == 0) bus.halt = ~bus.halt;
            step();
        end
        idle();
        bus.halt = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 10, memory word-address width; DW, 32, data width; STARVE_LIM, 4, consecutive denied fetch cycles before fetch priority boost.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- CLK  in  1  single system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- IF_REQ  in  1  instruction-fetch read request
- IF_ADDR  in  AW  fetch word address
- IF_ACK  out  1  fetch request accepted this cycle
- IF_RVALID  out  1  RDATA holds fetch data this cycle
- DM_REQ  in  1  data-memory request (LW/SW)
- DM_WE  in  1  1 = write, 0 = read
- DM_ADDR  in  AW  data word address
- DM_WDATA  in  DW  store data
- DM_ACK  out  1  data request accepted this cycle
- DM_RVALID  out  1  RDATA holds load data this cycle
- DBG_REQ  in  1  program-loader/debug request
- DBG_WE  in  1  1 = write, 0 = read
- DBG_ADDR  in  AW  debug word address
- DBG_WDATA  in  DW  debug write data
- DBG_ACK  out  1  debug request accepted this cycle
- DBG_RVALID  out  1  RDATA holds debug read data this cycle
- RDATA  out  DW  shared read return, qualified by the x_RVALID strobes
- HALT  in  1  core halt request (HLT retired or external)
- HALT_ACK  out  1  fetch stopped and memory quiescent
- MEM_EN  out  1  single-port memory enable
- MEM_WE  out  1  single-port memory write enable
- MEM_ADDR  out  AW  memory address
- MEM_WDATA  out  DW  memory write data
- MEM_RDATA  in  DW  memory read data, valid one cycle after MEM_EN with MEM_WE=0

Function
REQ-003 The block SHALL grant at most one requester per cycle; x_ACK is combinational from current requests and state, at most one ACK high per cycle.
REQ-004 Base priority SHALL be DBG > DM > IF.
REQ-005 Starvation counter SHALL increment each cycle IF_REQ=1, IF not granted, FSM in RUN; it clears on IF grant or IF_REQ=0 and saturates at STARVE_LIM.
REQ-006 When the counter equals STARVE_LIM, IF SHALL win over DM (not over DBG) in that cycle.
REQ-007 A requester SHALL hold REQ, WE, ADDR, WDATA stable until its ACK; it may present a new request the cycle after ACK, and back-to-back grants to the same requester SHALL be allowed.
REQ-008 Grant in cycle N SHALL drive MEM_EN=1, MEM_WE, MEM_ADDR, MEM_WDATA from registers in cycle N+1; with no grant, MEM_EN=0, MEM_WE=0.
REQ-009 A read granted in cycle N SHALL assert that requester's RVALID for exactly cycle N+2, with RDATA = MEM_RDATA passed through; writes produce no RVALID.
REQ-010 Owner of each in-flight read SHALL be tracked in a 2-stage pipeline so back-to-back reads by different requesters return in grant order.
REQ-011 FSM states SHALL be RUN, DRAIN, HALTED.
- RUN: all requesters eligible; HALT=1 -> DRAIN.
- DRAIN: IF never granted; DM and DBG eligible; HALT=0 -> RUN; HALT=1 with DM_REQ=0 and no read in flight -> HALTED.
- HALTED: only DBG granted; HALT_ACK=1; HALT=0 -> RUN.
REQ-012 HALT_ACK SHALL be registered and high only in HALTED.
REQ-013 DBG and DM requesting the same address in one cycle: DBG SHALL be served first and DM in a later cycle; no merging.
REQ-014 The starvation counter SHALL hold (not increment) outside RUN.

Reset
REQ-015 RST_N low SHALL immediately force state RUN, starvation counter 0, read-owner pipeline empty, and MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, HALT_ACK, all x_RVALID to 0.
REQ-016 Reads in flight at reset SHALL be discarded with no RVALID after release; x_ACK stays 0 while RST_N is low.
REQ-017 The first grant SHALL be possible in the first rising edge cycle after RST_N deasserts.

Verification
REQ-018 Scenarios:
- IF_REQ=1 at IF_ADDR 0..3 consecutive, MEM preloaded -> IF_ACK every cycle, IF_RVALID 2 cycles after each ACK, RDATA=MEM[0..3] in order.
- DM_REQ=1 read addr 40 and IF_REQ=1 continuously -> DM_ACK cycles 0-3, IF_ACK forced in cycle 4 (STARVE_LIM=4), counter returns 0.
- DBG write 0x15 addr 30 and DM read addr 30 same cycle -> DBG_ACK first, DM_ACK next cycle, DM_RVALID with RDATA=0x15.
- HALT=1 with DM read in flight, IF_REQ=1 -> no IF_ACK from HALT cycle on, HALT_ACK rises after DM_RVALID; DBG write in HALTED accepted; HALT=0 -> IF_ACK resumes.
- RST_N pulsed low cycle after an IF read grant -> no IF_RVALID, MEM_EN=0, HALT_ACK=0, counter 0 after release.
